pipe_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage RV32IMC pipeline. It drives the enable and flush controls of the PC, IF/ID, ID/EXE and EXE/MEM pipeline registers. Three events are handled:
- load-use hazards, resolved with a bubble;
- taken branches and jumps resolved in EXE, resolved with a wrong-path flush;
- multi-cycle divide operations, resolved with a start/done handshake and a pipeline freeze.

---
 rtl/hazard_pkg.sv | 5 +
 rtl/haz_loaduse_cmp.sv | 15 +
 rtl/pipe_hazard_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding and register constants for the hazard sequencer
package hazard_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, DIV_WAIT = 2'd1, REDIRECT = 2'd2} state_e;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/haz_loaduse_cmp.sv
// haz_loaduse_cmp: detects an ID source register that depends on a load still in EXE
module haz_loaduse_cmp
  import hazard_pkg::*;
(
  input  logic [4:0] id_rsA,
  input  logic [4:0] id_rsB,
  input  logic       id_uses_rsA,
  input  logic       id_uses_rsB,
  input  logic [4:0] exe_rd,
  input  logic       exe_is_load,
  output logic       lu
);
  assign lu = exe_is_load && exe_rd != REG_ZERO &&
              ((id_uses_rsA && id_rsA == exe_rd) || (id_uses_rsB && id_rsB == exe_rd));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for load-use, EXE redirects and multi-cycle divides.
// Define HAZ_PERF_CNT_EN to add saturating stall/flush performance counters.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [4:0] id_rsA,
  input  logic [4:0] id_rsB,
  input  logic       id_uses_rsA,
  input  logic       id_uses_rsB,
  input  logic [4:0] exe_rd,
  input  logic       exe_is_load,
  input  logic       exe_is_mc,
  input  logic       exe_redirect,
  input  logic       div_done,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       if_id_flush,
  output logic       id_exe_en,
  output logic       id_exe_flush,
  output logic       exe_mem_flush,
  output logic       div_start,
  output logic       busy
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] lu_stall_cnt,
  output logic [CNT_W-1:0] div_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);
  localparam logic [1:0] FC = 2'(FLUSH_CYCLES);
  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       lu;
  haz_loaduse_cmp u_lu (
    .id_rsA(id_rsA), .id_rsB(id_rsB), .id_uses_rsA(id_uses_rsA), .id_uses_rsB(id_uses_rsB),
    .exe_rd(exe_rd), .exe_is_load(exe_is_load), .lu(lu)
  );
  // Reset is folded into the next-state logic so the reset cycle also shows idle outputs
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_exe_en     = 1'b1;
    id_exe_flush  = 1'b0;
    exe_mem_flush = 1'b0;
    div_start     = 1'b0;
    busy          = state_q != RUN;
    if (!nrst) begin
      busy    = 1'b0;
      state_d = RUN;
      cnt_d   = 2'd0;
    end else if (state_q == DIV_WAIT) begin
      if (div_done) state_d = RUN;
      else {pc_en, if_id_en, id_exe_en, exe_mem_flush} = 4'b0001;
    end else if (exe_redirect) begin
      if_id_flush  = 1'b1;
      id_exe_flush = 1'b1;
      cnt_d        = FC;
      state_d      = FLUSH_CYCLES > 0 ? REDIRECT : RUN;
    end else if (state_q == REDIRECT) begin
      if_id_flush = 1'b1;
      cnt_d       = cnt_q - 2'd1;
      state_d     = cnt_q <= 2'd1 ? RUN : REDIRECT;
    end else if (exe_is_mc) begin
      {pc_en, if_id_en, id_exe_en, exe_mem_flush, div_start} = 5'b00011;
      state_d = DIV_WAIT;
    end else if (lu) begin
      {pc_en, if_id_en, id_exe_flush} = 3'b001;
    end
  end
  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end
`ifdef HAZ_PERF_CNT_EN
  logic             lu_inc, div_inc, flush_inc;
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d, div_cnt_q, div_cnt_d, flush_cnt_q, flush_cnt_d;
  assign lu_inc    = state_q == RUN && !exe_redirect && !exe_is_mc && lu;
  assign div_inc   = state_q == DIV_WAIT && !div_done;
  assign flush_inc = state_q != DIV_WAIT && exe_redirect;
  always_comb begin
    lu_cnt_d    = !nrst ? '0 : lu_cnt_q + CNT_W'(lu_inc && !(&lu_cnt_q));
    div_cnt_d   = !nrst ? '0 : div_cnt_q + CNT_W'(div_inc && !(&div_cnt_q));
    flush_cnt_d = !nrst ? '0 : flush_cnt_q + CNT_W'(flush_inc && !(&flush_cnt_q));
  end
  always_ff @(posedge clk) begin
    lu_cnt_q    <= lu_cnt_d;
    div_cnt_q   <= div_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end
  assign lu_stall_cnt  = lu_cnt_q;
  assign div_stall_cnt = div_cnt_q;
  assign flush_cnt     = flush_cnt_q;
`endif
endmodule
